// File: rtl/cash_pkg.sv
// Shared types and default denominations for the vending credit path.
package cash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    REFUND
  } cash_state_e;

  localparam int unsigned UNIT     = 5;
  localparam int unsigned MAX_NOTE = 20;
  localparam int unsigned PRICE    = 30;

endpackage

// File: rtl/note_validator.sv
// Combinational denomination check: nonzero, a multiple of UNIT, and no larger than MAX_NOTE.
module note_validator #(
  parameter int unsigned UNIT     = cash_pkg::UNIT,
  parameter int unsigned MAX_NOTE = cash_pkg::MAX_NOTE,
  parameter int unsigned NOTE_W   = 5
) (
  input  logic [NOTE_W-1:0] note_value,
  output logic              valid
);

  logic [31:0] w_value;

  assign w_value = 32'(note_value);
  assign valid   = (w_value != 32'd0) &&
                   ((w_value % UNIT) == 32'd0) &&
                   (w_value <= MAX_NOTE);

endmodule

// File: rtl/cash_accumulator.sv
// Credit accumulator: takes notes over valid/ready, vends at PRICE with change,
// refunds on cancel and counts completed sales. All outputs are registered.
module cash_accumulator #(
  parameter int unsigned PRICE    = cash_pkg::PRICE,
  parameter int unsigned UNIT     = cash_pkg::UNIT,
  parameter int unsigned MAX_NOTE = cash_pkg::MAX_NOTE,
  parameter int unsigned NOTE_W   = 5,
  parameter int unsigned CREDIT_W = 6,
  parameter int unsigned SALES_W  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                note_valid,
  input  logic [NOTE_W-1:0]   note_value,
  output logic                note_ready,
  input  logic                cancel,
  output logic                reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change,
  output logic [SALES_W-1:0]  sales
);
  import cash_pkg::*;

  // One extra bit so credit + note never wraps before the PRICE compare.
  localparam int unsigned      SUM_W     = CREDIT_W + 1;
  localparam logic [SUM_W-1:0] PRICE_SUM = SUM_W'(PRICE);

  cash_state_e         r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_change;
  logic                r_vend;
  logic                r_change_valid;
  logic                r_reject;
  logic [SALES_W-1:0]  r_sales;

  logic                w_note_ok;
  logic                w_transfer;
  logic [SUM_W-1:0]    w_total;

  note_validator #(
    .UNIT     (UNIT),
    .MAX_NOTE (MAX_NOTE),
    .NOTE_W   (NOTE_W)
  ) u_validator (
    .note_value (note_value),
    .valid      (w_note_ok)
  );

  assign note_ready = (r_state == IDLE) || (r_state == COLLECT);
  assign w_transfer = note_valid && note_ready;
  assign w_total    = {1'b0, r_credit} + SUM_W'(note_value);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_change       <= '0;
      r_vend         <= 1'b0;
      r_change_valid <= 1'b0;
      r_reject       <= 1'b0;
      r_sales        <= '0;
    end else begin
      r_vend         <= 1'b0;
      r_change_valid <= 1'b0;
      r_change       <= '0;
      r_reject       <= 1'b0;
      case (r_state)
        IDLE, COLLECT: begin
          // A note arriving alongside cancel is refused, even in IDLE.
          if (w_transfer && (cancel || !w_note_ok)) begin
            r_reject <= 1'b1;
          end
          if (cancel && (r_state == COLLECT)) begin
            r_state        <= REFUND;
            r_change_valid <= 1'b1;
            r_change       <= r_credit;
            r_credit       <= '0;
          end else if (w_transfer && w_note_ok && !cancel) begin
            if (w_total >= PRICE_SUM) begin
              r_state        <= VEND;
              r_vend         <= 1'b1;
              r_change_valid <= 1'b1;
              r_change       <= CREDIT_W'(w_total - PRICE_SUM);
              r_credit       <= '0;
              r_sales        <= r_sales + SALES_W'(1);
            end else begin
              r_state  <= COLLECT;
              r_credit <= CREDIT_W'(w_total);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign credit       = r_credit;
  assign change       = r_change;
  assign vend         = r_vend;
  assign change_valid = r_change_valid;
  assign reject       = r_reject;
  assign sales        = r_sales;

endmodule

// File: tb/tb_cash_accumulator.sv
// Directed bench for cash_accumulator; a second instance with SALES_W=2 checks counter wrap.
module tb_cash_accumulator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       note_valid = 1'b0;
  logic [4:0] note_value = 5'd0;
  logic       cancel = 1'b0;

  logic       note_ready, reject, vend, change_valid;
  logic [5:0] credit, change;
  logic [7:0] sales;

  logic       s_note_ready, s_reject, s_vend, s_change_valid;
  logic [5:0] s_credit, s_change;
  logic [1:0] s_sales;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  cash_accumulator u_dut (
    .clock(clock), .reset(reset), .note_valid(note_valid), .note_value(note_value),
    .note_ready(note_ready), .cancel(cancel), .reject(reject), .credit(credit),
    .vend(vend), .change_valid(change_valid), .change(change), .sales(sales)
  );

  cash_accumulator #(.SALES_W(2)) u_small (
    .clock(clock), .reset(reset), .note_valid(note_valid), .note_value(note_value),
    .note_ready(s_note_ready), .cancel(cancel), .reject(s_reject), .credit(s_credit),
    .vend(s_vend), .change_valid(s_change_valid), .change(s_change), .sales(s_sales)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic give(input logic [4:0] v);
    note_valid = 1'b1;
    note_value = v;
  endtask

  task automatic idle_in();
    note_valid = 1'b0;
    note_value = 5'd0;
    cancel     = 1'b0;
  endtask

  initial begin
    // reset
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_ready", 32'(note_ready), 1);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_vend", 32'(vend), 0);
    chk("rst_cv", 32'(change_valid), 0);
    chk("rst_change", 32'(change), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_sales", 32'(sales), 0);
    $display("[TB] reset checked");

    // 10 + 10 + 10 -> exact vend
    give(5'd10); step();
    chk("t1_credit10", 32'(credit), 10);
    chk("t1_ready_collect", 32'(note_ready), 1);
    give(5'd10); step();
    chk("t1_credit20", 32'(credit), 20);
    give(5'd10); step();
    chk("t1_vend", 32'(vend), 1);
    chk("t1_cv", 32'(change_valid), 1);
    chk("t1_change", 32'(change), 0);
    chk("t1_credit0", 32'(credit), 0);
    chk("t1_sales", 32'(sales), 1);
    chk("t1_ready_vend", 32'(note_ready), 0);
    idle_in(); step();
    chk("t1_vend_drop", 32'(vend), 0);
    chk("t1_cv_drop", 32'(change_valid), 0);
    chk("t1_ready_idle", 32'(note_ready), 1);
    $display("[TB] 10+10+10 vend");

    // 20 + 20 -> vend with change 10; note held during VEND is not taken
    give(5'd20); step();
    chk("t2_credit20", 32'(credit), 20);
    step();
    chk("t2_vend", 32'(vend), 1);
    chk("t2_change", 32'(change), 10);
    chk("t2_credit0", 32'(credit), 0);
    chk("t2_sales", 32'(sales), 2);
    step();
    chk("t2_no_reject_vend", 32'(reject), 0);
    chk("t2_not_taken", 32'(credit), 0);
    chk("t2_ready_back", 32'(note_ready), 1);
    idle_in(); step();
    chk("t2_still_idle", 32'(credit), 0);
    $display("[TB] 20+20 vend with change");

    // 5 + 5 then cancel -> refund 10
    give(5'd5); step();
    chk("t3_credit5", 32'(credit), 5);
    give(5'd5); step();
    chk("t3_credit10", 32'(credit), 10);
    idle_in(); cancel = 1'b1; step();
    chk("t3_cv", 32'(change_valid), 1);
    chk("t3_change", 32'(change), 10);
    chk("t3_no_vend", 32'(vend), 0);
    chk("t3_credit0", 32'(credit), 0);
    chk("t3_ready_refund", 32'(note_ready), 0);
    idle_in(); step();
    chk("t3_ready_idle", 32'(note_ready), 1);
    chk("t3_change_clr", 32'(change), 0);
    $display("[TB] cancel refund");

    // invalid notes 7 and 25
    give(5'd7); step();
    chk("t4_reject7", 32'(reject), 1);
    chk("t4_credit7", 32'(credit), 0);
    give(5'd25); step();
    chk("t4_reject25", 32'(reject), 1);
    chk("t4_credit25", 32'(credit), 0);
    idle_in(); step();
    chk("t4_reject_drop", 32'(reject), 0);
    chk("t4_sales", 32'(sales), 2);
    $display("[TB] invalid notes rejected");

    // credit 10, then cancel with note 20 -> reject and refund
    give(5'd10); step();
    chk("t5_credit10", 32'(credit), 10);
    give(5'd20); cancel = 1'b1; step();
    chk("t5_reject", 32'(reject), 1);
    chk("t5_cv", 32'(change_valid), 1);
    chk("t5_change", 32'(change), 10);
    chk("t5_no_vend", 32'(vend), 0);
    chk("t5_credit0", 32'(credit), 0);
    idle_in(); step();
    // cancel with a note in IDLE: reject only, no refund pulse
    give(5'd10); cancel = 1'b1; step();
    chk("t5_idle_reject", 32'(reject), 1);
    chk("t5_idle_no_cv", 32'(change_valid), 0);
    chk("t5_idle_credit", 32'(credit), 0);
    idle_in(); step();
    $display("[TB] cancel wins over note");

    // reset during VEND
    give(5'd20); step();
    give(5'd10); step();
    chk("t6_vend", 32'(vend), 1);
    chk("t6_sales", 32'(sales), 3);
    idle_in(); reset = 1'b1; #2;
    chk("t6_rst_vend", 32'(vend), 0);
    chk("t6_rst_cv", 32'(change_valid), 0);
    chk("t6_rst_sales", 32'(sales), 0);
    chk("t6_rst_credit", 32'(credit), 0);
    step();
    reset = 1'b0;
    step();
    chk("t6_ready", 32'(note_ready), 1);
    $display("[TB] reset during vend");

    // four vends: 2-bit counter wraps 3 -> 0
    for (int k = 1; k <= 4; k++) begin
      give(5'd20); step();
      give(5'd10); step();
      chk("t7_vend", 32'(vend), 1);
      chk("t7_sales", 32'(sales), 32'(k));
      chk("t7_small_sales", 32'(s_sales), 32'(k % 4));
      idle_in(); step();
      $display("[TB] wrap vend %0d small sales=%0d", k, s_sales);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cash_accumulator.md
# cash_accumulator

Parametrised credit accumulator for the bar-code vending front end. It accepts notes over a valid/ready handshake and rejects unsupported denominations. It tracks running credit, vends when credit reaches `PRICE`, returns change, refunds on cancel and counts completed sales. It sits between the note-reader decoder and the dispense/change controller, replacing the fixed 10/20/30-euro acceptor with a configurable one.

## Interface
- `PRICE`, 30: vend threshold in euros; must be > 0.
- `UNIT`, 5: smallest accepted denomination; a valid note is a nonzero multiple of `UNIT`.
- `MAX_NOTE`, 20: largest accepted denomination.
- `NOTE_W`, 5: width of `note_value`.
- `CREDIT_W`, 6: width of `credit` and `change`; must hold `PRICE + MAX_NOTE - UNIT`.
- `SALES_W`, 8: width of the sales counter.

Ports (`reset` is asynchronous, active-high; `clock` is the clock):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous active-high reset.
- `note_valid`  in  1  note presented.
- `note_value`  in  NOTE_W  note denomination in euros.
- `note_ready`  out  1  block can take a note this cycle.
- `cancel`  in  1  refund request, level sampled each edge.
- `reject`  out  1  one-cycle pulse: the presented note was refused.
- `credit`  out  CREDIT_W  current accumulated credit.
- `vend`  out  1  one-cycle dispense pulse.
- `change_valid`  out  1  one-cycle pulse qualifying `change`.
- `change`  out  CREDIT_W  amount to return; 0 when `change_valid` is low.
- `sales`  out  SALES_W  completed vends, wraps modulo 2^SALES_W.

## Operation
- States:
  - IDLE: credit = 0.
  - COLLECT: 0 < credit < PRICE.
  - VEND: one cycle.
  - REFUND: one cycle.
- `note_ready` is 1 in IDLE and COLLECT and 0 in VEND and REFUND. A transfer occurs when `note_valid && note_ready`.
- A note is valid iff `note_value != 0`, `note_value % UNIT == 0` and `note_value <= MAX_NOTE`.
- An invalid transfer leaves credit and state unchanged and pulses `reject` on the next cycle.
- Valid transfer, IDLE or COLLECT: compute total = credit + note_value at CREDIT_W+1 bits, with no truncation.
  - total < PRICE: credit ← total, state → COLLECT.
  - total ≥ PRICE: state → VEND, `vend` ← 1, `change_valid` ← 1, `change` ← total − PRICE, credit ← 0, `sales` ← sales + 1.
- `cancel` in COLLECT: state → REFUND, `change_valid` ← 1, `change` ← credit, credit ← 0.
- `cancel` in IDLE is ignored; no pulse is generated.
- Cancel together with a transfer in the same cycle: cancel wins. The note is not added and `reject` pulses. This applies in IDLE as well: the note is rejected and there is no refund pulse.
- `note_valid` in VEND or REFUND is not accepted. It raises no `reject`, because `note_ready` is low and the reader must hold the note.
- VEND and REFUND return to IDLE unconditionally on the next edge.
- `cancel` during VEND or REFUND is ignored.
- `reset` at any point, including mid-VEND: state → IDLE and all outputs → 0, with `note_ready` → 1 once reset deasserts. The in-flight credit is discarded.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `note_ready` is decoded from the state register.
- A transfer sampled at edge N is reflected in `credit`, `vend`, `change_valid`, `change`, `reject` and `sales` after edge N, i.e. with 1-cycle latency.
- `vend`, `change_valid` and `reject` are high for exactly one cycle.
- Minimum spacing between a vend and the next accepted note is 2 edges: the VEND cycle, then IDLE.
- Reset values:
  - state IDLE.
  - `credit`, `change`, `sales` = 0.
  - `vend`, `change_valid`, `reject` = 0.
  - `note_ready` = 1.
- `sales` wraps from 2^SALES_W−1 to 0 without a flag.

## Structure
- Package `cash_pkg` holds the state enum (IDLE, COLLECT, VEND, REFUND) and the default denomination constants (`UNIT`, `MAX_NOTE`, `PRICE`).
- Sub-module `note_validator` is purely combinational: it takes `note_value` and outputs `valid`, parametrised by `UNIT`, `MAX_NOTE` and `NOTE_W`. It is shared with the reader self-test.
- The FSM, adder/subtractor and sales counter live in `cash_accumulator`.

## Test plan
- Reset, then notes 10, 10, 10 → credit 10 then 20, then `vend`=1 with `change`=0, `sales`=1, credit 0.
- Notes 20, 20 → `vend`=1, `change_valid`=1, `change`=10, credit 0.
- Notes 5, 5, then `cancel` → `change_valid`=1, `change`=10, no `vend`, state IDLE.
- Note 7, then note 25 → `reject` pulses twice, credit stays 0, `sales` unchanged.
- Credit 10, then `cancel` together with note 20 → `reject`=1, `change`=10, no `vend`.
- Assert `reset` during the VEND cycle → all outputs 0 next cycle.
- With `SALES_W`=2, run 4 vends → `sales` wraps 3 → 0.
